// File: rtl/median_filter_engine_if.sv
`default_nettype none
// ============================================================================
// median_filter_engine_if : control and pixel-memory bus of the median engine
// Rev 1.0 - initial release
// ============================================================================
interface median_filter_engine_if;
  logic        Mf_Start;
  logic        Mf_Busy;
  logic        Mf_Done;
  logic        Mf_Rd_En;
  logic [31:0] Mf_Rd_Addr;
  logic [23:0] Mf_Rd_Data;
  logic        Mf_Wr_En;
  logic [31:0] Mf_Wr_Addr;
  logic [23:0] Mf_Wr_Data;

  // Engine side: the sole master of the memory read and write ports.
  modport master (
    input  Mf_Start,
    input  Mf_Rd_Data,
    output Mf_Busy,
    output Mf_Done,
    output Mf_Rd_En,
    output Mf_Rd_Addr,
    output Mf_Wr_En,
    output Mf_Wr_Addr,
    output Mf_Wr_Data
  );

  modport slave (
    output Mf_Start,
    output Mf_Rd_Data,
    input  Mf_Busy,
    input  Mf_Done,
    input  Mf_Rd_En,
    input  Mf_Rd_Addr,
    input  Mf_Wr_En,
    input  Mf_Wr_Addr,
    input  Mf_Wr_Data
  );
endinterface
`default_nettype wire

// File: rtl/median_filter_engine.sv
`default_nettype none
// ============================================================================
// median_filter_engine : per-channel 3x3 median filter over a 24-bit RGB frame
// Rev 1.0 - initial release
// ============================================================================
module median_filter_engine #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter logic [31:0] SRC_BASE   = 32'h0000_0000,
  parameter logic [31:0] DST_BASE   = 32'h0020_0000
) (
  input  wire logic              Mf_Clk,
  input  wire logic              Mf_Reset_n,
  median_filter_engine_if.master bus
);

  localparam int unsigned XW = $clog2(IMG_WIDTH);
  localparam int unsigned YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_SORT  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef logic [8:0][23:0] win_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [1:0]    row_q, row_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    sort_q, sort_d;
  logic          cap_en_q, cap_en_d;
  logic [3:0]    cap_slot_q, cap_slot_d;
  win_t          slot_q, slot_d;
  logic [31:0]   rd_addr_q;
  logic [31:0]   wr_addr_q;
  logic [23:0]   wr_data_q;

  logic          w_border;
  logic [1:0]    w_row;
  logic [1:0]    w_col;
  logic [3:0]    w_slot_sel;
  logic [31:0]   w_rd_idx;
  logic [31:0]   w_rd_pix_addr;
  logic [31:0]   w_wr_pix_addr;

  logic          w_busy;
  logic          w_done;
  logic          w_rd_en;
  logic [31:0]   w_rd_addr;
  logic          w_wr_en;
  logic [31:0]   w_wr_addr;
  logic [23:0]   w_wr_data;

  // One odd-even transposition pass; pairs within a pass are disjoint.
  function automatic win_t sort_pass(input win_t s, input logic odd);
    win_t r;
    r = s;
    for (int i = 0; i < 8; i++) begin
      if (odd == i[0]) begin
        for (int ch = 0; ch < 3; ch++) begin
          if (r[i][8*ch +: 8] > r[i+1][8*ch +: 8]) begin
            r[i][8*ch +: 8]   = s[i+1][8*ch +: 8];
            r[i+1][8*ch +: 8] = s[i][8*ch +: 8];
          end
        end
      end
    end
    return r;
  endfunction

  // Border pixels reuse the window path with the offset pinned to the centre.
  always_comb begin
    w_border      = (x_q == '0) || (x_q == X_LAST) || (y_q == '0) || (y_q == Y_LAST);
    w_row         = w_border ? 2'd1 : row_q;
    w_col         = w_border ? 2'd1 : col_q;
    w_slot_sel    = ({2'b00, w_row} * 4'd3) + {2'b00, w_col};
    w_rd_idx      = ((32'(y_q) + 32'(w_row) - 32'd1) * IMG_WIDTH)
                  + 32'(x_q) + 32'(w_col) - 32'd1;
    w_rd_pix_addr = SRC_BASE + (32'd3 * w_rd_idx);
    w_wr_pix_addr = DST_BASE + (32'd3 * ((32'(y_q) * IMG_WIDTH) + 32'(x_q)));
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    row_d      = row_q;
    col_d      = col_q;
    sort_d     = sort_q;
    cap_en_d   = 1'b0;
    cap_slot_d = cap_slot_q;
    slot_d     = slot_q;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_rd_en    = 1'b0;
    w_rd_addr  = rd_addr_q;
    w_wr_en    = 1'b0;
    w_wr_addr  = wr_addr_q;
    w_wr_data  = wr_data_q;

    if (cap_en_q) begin
      slot_d[cap_slot_q] = bus.Mf_Rd_Data;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.Mf_Start) begin
          x_d     = '0;
          y_d     = '0;
          row_d   = 2'd0;
          col_d   = 2'd0;
          state_d = S_READ;
        end
      end

      S_READ: begin
        w_busy     = 1'b1;
        w_rd_en    = 1'b1;
        w_rd_addr  = w_rd_pix_addr;
        cap_en_d   = 1'b1;
        cap_slot_d = w_slot_sel;
        if (w_border || ((row_q == 2'd2) && (col_q == 2'd2))) begin
          row_d   = 2'd0;
          col_d   = 2'd0;
          state_d = S_WAIT;
        end else if (col_q == 2'd2) begin
          col_d = 2'd0;
          row_d = row_q + 2'd1;
        end else begin
          col_d = col_q + 2'd1;
        end
      end

      S_WAIT: begin
        w_busy  = 1'b1;
        sort_d  = 4'd0;
        state_d = w_border ? S_WRITE : S_SORT;
      end

      S_SORT: begin
        w_busy = 1'b1;
        slot_d = sort_pass(slot_q, sort_q[0]);
        sort_d = sort_q + 4'd1;
        if (sort_q == 4'd8) begin
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        w_busy    = 1'b1;
        w_wr_en   = 1'b1;
        w_wr_addr = w_wr_pix_addr;
        w_wr_data = slot_q[4];
        state_d   = S_READ;
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q == Y_LAST) begin
            state_d = S_DONE;
          end else begin
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end

      S_DONE: begin
        w_done  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Mf_Clk) begin
    if (!Mf_Reset_n) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      row_q      <= 2'd0;
      col_q      <= 2'd0;
      sort_q     <= 4'd0;
      cap_en_q   <= 1'b0;
      cap_slot_q <= 4'd0;
      slot_q     <= '0;
      rd_addr_q  <= 32'd0;
      wr_addr_q  <= 32'd0;
      wr_data_q  <= 24'd0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_q      <= row_d;
      col_q      <= col_d;
      sort_q     <= sort_d;
      cap_en_q   <= cap_en_d;
      cap_slot_q <= cap_slot_d;
      slot_q     <= slot_d;
      rd_addr_q  <= w_rd_addr;
      wr_addr_q  <= w_wr_addr;
      wr_data_q  <= w_wr_data;
    end
  end

  assign bus.Mf_Busy    = w_busy;
  assign bus.Mf_Done    = w_done;
  assign bus.Mf_Rd_En   = w_rd_en;
  assign bus.Mf_Rd_Addr = w_rd_addr;
  assign bus.Mf_Wr_En   = w_wr_en;
  assign bus.Mf_Wr_Addr = w_wr_addr;
  assign bus.Mf_Wr_Data = w_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_median_filter_engine.sv
`default_nettype none
// ============================================================================
// tb_median_filter_engine : directed bench for 3x3 and 4x4 median engines
// Rev 1.0 - initial release
// ============================================================================
module tb_median_filter_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  median_filter_engine_if bus3 ();
  median_filter_engine_if bus4 ();

  median_filter_engine #(
    .IMG_WIDTH (3),
    .IMG_HEIGHT(3),
    .SRC_BASE  (32'h0000_0000),
    .DST_BASE  (32'h0020_0000)
  ) dut3 (
    .Mf_Clk    (clk),
    .Mf_Reset_n(rst_n),
    .bus       (bus3)
  );

  median_filter_engine #(
    .IMG_WIDTH (4),
    .IMG_HEIGHT(4),
    .SRC_BASE  (32'h0000_0000),
    .DST_BASE  (32'h0020_0000)
  ) dut4 (
    .Mf_Clk    (clk),
    .Mf_Reset_n(rst_n),
    .bus       (bus4)
  );

  logic [23:0] src3 [0:8];
  logic [23:0] src4 [0:15];

  always @(posedge clk) begin
    if (!rst_n) begin
      bus3.Mf_Rd_Data <= 24'd0;
      bus4.Mf_Rd_Data <= 24'd0;
    end else begin
      if (bus3.Mf_Rd_En) bus3.Mf_Rd_Data <= src3[4'(bus3.Mf_Rd_Addr / 32'd3)];
      if (bus4.Mf_Rd_En) bus4.Mf_Rd_Data <= src4[4'(bus4.Mf_Rd_Addr / 32'd3)];
    end
  end

  int          busy3 = 0;
  int          done3 = 0;
  int          busy4 = 0;
  int          done4 = 0;
  int          ovl   = 0;
  logic [31:0] wa3 [$];
  logic [23:0] wd3 [$];
  logic [31:0] ra3 [$];
  logic [31:0] wa4 [$];
  logic [23:0] wd4 [$];
  logic [31:0] ra4 [$];

  always @(negedge clk) begin
    if (bus3.Mf_Busy) busy3 <= busy3 + 1;
    if (bus3.Mf_Done) done3 <= done3 + 1;
    if (bus4.Mf_Busy) busy4 <= busy4 + 1;
    if (bus4.Mf_Done) done4 <= done4 + 1;
    if ((bus3.Mf_Rd_En && bus3.Mf_Wr_En) || (bus4.Mf_Rd_En && bus4.Mf_Wr_En)) ovl <= ovl + 1;
    if (bus3.Mf_Wr_En) begin
      wa3.push_back(bus3.Mf_Wr_Addr);
      wd3.push_back(bus3.Mf_Wr_Data);
    end
    if (bus3.Mf_Rd_En) ra3.push_back(bus3.Mf_Rd_Addr);
    if (bus4.Mf_Wr_En) begin
      wa4.push_back(bus4.Mf_Wr_Addr);
      wd4.push_back(bus4.Mf_Wr_Data);
    end
    if (bus4.Mf_Rd_En) ra4.push_back(bus4.Mf_Rd_Addr);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start3();
    bus3.Mf_Start = 1'b1;
    tick();
    bus3.Mf_Start = 1'b0;
  endtask

  task automatic wait_done3(input string tag, input int budget);
    int d0;
    int n;
    d0 = done3;
    n  = 0;
    while ((done3 == d0) && (n < budget)) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 32'(done3 - d0), 32'd1);
  endtask

  task automatic load_salt();
    for (int k = 0; k < 9; k++) src3[k] = 24'h102030;
    src3[4] = 24'hFFFFFF;
  endtask

  int b0, d0, w0, r0, w1, r1, n;
  logic [31:0] exp_rd [0:8];

  initial begin
    rst_n         = 1'b0;
    bus3.Mf_Start = 1'b1;
    bus4.Mf_Start = 1'b1;
    for (int k = 0; k < 9; k++)  src3[k] = 24'd0;
    for (int k = 0; k < 16; k++) src4[k] = 24'd0;

    // Reset held with Start asserted
    tick();
    tick();
    check("rst_busy",    32'(bus3.Mf_Busy),  32'd0);
    check("rst_done",    32'(bus3.Mf_Done),  32'd0);
    check("rst_rd_en",   32'(bus3.Mf_Rd_En), 32'd0);
    check("rst_wr_en",   32'(bus3.Mf_Wr_En), 32'd0);
    check("rst_rd_addr", bus3.Mf_Rd_Addr,    32'd0);
    check("rst_wr_addr", bus3.Mf_Wr_Addr,    32'd0);
    check("rst_wr_data", 32'(bus3.Mf_Wr_Data), 32'd0);
    check("rst_busy4",   32'(bus4.Mf_Busy),  32'd0);
    check("rst_access",  32'(wa3.size() + ra3.size() + wa4.size() + ra4.size()), 32'd0);
    bus3.Mf_Start = 1'b0;
    bus4.Mf_Start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Salt removal
    load_salt();
    b0 = busy3; d0 = done3; w0 = wa3.size();
    pulse_start3();
    wait_done3("salt", 200);
    repeat (4) tick();
    check("salt_nwr",  32'(wa3.size() - w0), 32'd9);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("salt_addr%0d", i), wa3[w0+i], 32'h0020_0000 + 32'(3*i));
      check($sformatf("salt_data%0d", i), 32'(wd3[w0+i]), 32'h102030);
    end
    check("salt_busy", 32'(busy3 - b0), 32'd44);
    check("salt_done", 32'(done3 - d0), 32'd1);

    // Channel independence, ascending R / descending G
    for (int k = 0; k < 9; k++) src3[k] = {8'(k), 8'(8 - k), 8'h80};
    w0 = wa3.size();
    pulse_start3();
    wait_done3("chan1", 200);
    tick();
    check("chan1_centre", 32'(wd3[w0+4]), 32'h040480);
    check("chan1_corner0", 32'(wd3[w0+0]), 32'h000880);
    check("chan1_corner8", 32'(wd3[w0+8]), 32'h080080);

    for (int k = 0; k < 9; k++) src3[k] = {8'(9 - k), 8'h55, 8'h55};
    w0 = wa3.size();
    pulse_start3();
    wait_done3("chan2", 200);
    tick();
    check("chan2_centre", 32'(wd3[w0+4]), 32'h055555);

    // 4x4 address sequence
    for (int k = 0; k < 16; k++) src4[k] = {8'(k), 8'(15 - k), 8'(3 * k)};
    exp_rd[0] = 32'h00; exp_rd[1] = 32'h03; exp_rd[2] = 32'h06;
    exp_rd[3] = 32'h0C; exp_rd[4] = 32'h0F; exp_rd[5] = 32'h12;
    exp_rd[6] = 32'h18; exp_rd[7] = 32'h1B; exp_rd[8] = 32'h1E;
    b0 = busy4; d0 = done4; w0 = wa4.size(); r0 = ra4.size();
    bus4.Mf_Start = 1'b1;
    tick();
    bus4.Mf_Start = 1'b0;
    n = 0;
    while ((done4 == d0) && (n < 400)) begin
      tick();
      n++;
    end
    tick();
    check("a4_done",  32'(done4 - d0), 32'd1);
    check("a4_nwr",   32'(wa4.size() - w0), 32'd16);
    check("a4_nrd",   32'(ra4.size() - r0), 32'd48);
    check("a4_first", wa4[w0], 32'h0020_0000);
    check("a4_last",  wa4[w0+15], 32'h0020_002D);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("a4_rd11_%0d", i), ra4[r0+5+i], exp_rd[i]);
    end
    check("a4_med11", 32'(wd4[w0+5]),  32'h050A0F);
    check("a4_med22", 32'(wd4[w0+10]), 32'h0A051E);
    check("a4_brd00", 32'(wd4[w0+0]),  32'h000F00);
    check("a4_busy",  32'(busy4 - b0), 32'd116);

    // Start held high through the whole frame
    load_salt();
    b0 = busy3; d0 = done3; w0 = wa3.size();
    bus3.Mf_Start = 1'b1;
    wait_done3("hold", 200);
    bus3.Mf_Start = 1'b0;
    repeat (5) tick();
    check("hold_done", 32'(done3 - d0), 32'd1);
    check("hold_busy", 32'(busy3 - b0), 32'd44);
    check("hold_nwr",  32'(wa3.size() - w0), 32'd9);
    check("hold_idle", 32'(bus3.Mf_Busy), 32'd0);

    // Reset during the SORT of pixel (1,1)
    b0 = busy3; w0 = wa3.size();
    pulse_start3();
    n = 0;
    while (((busy3 - b0) < 25) && (n < 100)) begin
      tick();
      n++;
    end
    check("mid_reached_sort", 32'(busy3 - b0), 32'd25);
    rst_n = 1'b0;
    tick();
    tick();
    check("mid_wr_before", 32'(wa3.size() - w0), 32'd4);
    rst_n = 1'b1;
    w1 = wa3.size();
    repeat (30) tick();
    check("mid_no_wr",  32'(wa3.size() - w1), 32'd0);
    check("mid_busy",   32'(bus3.Mf_Busy), 32'd0);
    check("mid_rd_en",  32'(bus3.Mf_Rd_En), 32'd0);
    r1 = ra3.size();
    w1 = wa3.size();
    pulse_start3();
    wait_done3("mid_restart", 200);
    tick();
    check("mid_nrd", 32'(ra3.size() > r1), 32'd1);
    check("mid_first_rd", ra3[r1], 32'h0000_0000);
    check("mid_nwr", 32'(wa3.size() - w1), 32'd9);
    check("mid_centre", 32'(wd3[w1+4]), 32'h102030);

    check("no_overlap", 32'(ovl), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
